// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC unified-memory arbiter.
// Holds the FSM state encoding, the owner encoding, the counter width and the
// default address/data widths.
package sisc_pkg;

  localparam int unsigned SISC_AW = 16;
  localparam int unsigned SISC_DW = 32;

  // Wait and burst counters; wide enough for MEM_LAT / MAX_DBURST up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/sisc_arb_pri.sv
// Two-way priority select between instruction fetch and data access.
// Data wins a tie unless the data burst limit has been reached, in which case
// the pending fetch is let through.
// Ports:
//   if_req, d_req : raw requests
//   burst_cnt     : consecutive data grants made while a fetch was pending
//   grant_if      : fetch would be granted (combinational)
//   grant_d       : data would be granted (combinational)
module sisc_arb_pri
  import sisc_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             grant_if,
  output logic             grant_d
);

  logic burst_hit;

  // At most one grant is ever high.
  always_comb begin
    burst_hit = (burst_cnt == CNT_W'(MAX_DBURST));
    grant_d   = d_req & ~(if_req & burst_hit);
    grant_if  = if_req & ~grant_d;
  end

endmodule

// File: rtl/sisc_mem_arb.sv
// Arbiter and sequencer for a single-ported unified memory shared by
// instruction fetch and data load/store.
// Ports:
//   clk, rst_f                          : clock, async active-low reset
//   if_req/if_addr -> if_gnt/if_rdy/if_rdata     : fetch channel
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rdy/d_rdata : data channel
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata  : memory side
//   busy                                : state is not IDLE
// Each transaction occupies the memory for MEM_LAT cycles, followed by one
// DONE cycle carrying the rdy pulse; a new request can be accepted in DONE.
module sisc_mem_arb
  import sisc_pkg::*;
#(
  parameter int unsigned AW         = SISC_AW,
  parameter int unsigned DW         = SISC_DW,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rdy,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rdy,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DBURST);

  state_t           state;
  logic             owner;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] burst_cnt;

  logic grant_if;
  logic grant_d;
  logic arb_open;
  logic acc_if;
  logic acc_d;

  sisc_arb_pri #(
    .MAX_DBURST(MAX_DBURST)
  ) u_pri (
    .if_req   (if_req),
    .d_req    (d_req),
    .burst_cnt(burst_cnt),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Requests are only looked at between accesses.
  always_comb begin
    arb_open = (state == IDLE) || (state == DONE);
    acc_if   = arb_open & grant_if;
    acc_d    = arb_open & grant_d;
  end

  // FSM, counters, memory-side registers and response registers.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      if_gnt    <= 1'b0;
      if_rdy    <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rdy     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt <= 1'b0;
      d_gnt  <= 1'b0;
      if_rdy <= 1'b0;
      d_rdy  <= 1'b0;

      if (acc_if || acc_d) begin
        // Accept edge: latch the winner's request into the memory port.
        state     <= ACCESS;
        busy      <= 1'b1;
        owner     <= acc_d ? OWN_D : OWN_IF;
        mem_en    <= 1'b1;
        mem_we    <= acc_d & d_we;
        mem_addr  <= acc_d ? d_addr : if_addr;
        mem_wdata <= acc_d ? d_wdata : '0;
        wait_cnt  <= WAIT_INIT;
        if_gnt    <= acc_if;
        d_gnt     <= acc_d;
        // Count data grants that made a fetch wait; saturate at the limit.
        if (acc_d && if_req) begin
          burst_cnt <= (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + CNT_W'(1);
        end else begin
          burst_cnt <= '0;
        end
      end else begin
        case (state)
          ACCESS: begin
            if (wait_cnt == '0) begin
              state  <= DONE;
              mem_en <= 1'b0;
              mem_we <= 1'b0;
              if (owner == OWN_IF) begin
                if_rdy <= 1'b1;
                if (!mem_we) if_rdata <= mem_rdata;
              end else begin
                d_rdy <= 1'b1;
                if (!mem_we) d_rdata <= mem_rdata;
              end
            end else begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: one instance at MEM_LAT = 2 and one at
// MEM_LAT = 1, sharing the request inputs, each with its own memory model.
module tb_sisc_mem_arb;

  logic        clk;
  logic        rst_f;
  logic        if_req;
  logic [15:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt,  if_rdy,  d_gnt,  d_rdy,  mem_en,  mem_we,  busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        if_gnt1, if_rdy1, d_gnt1, d_rdy1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;

  logic [31:0] mem  [0:63];
  logic [31:0] mem1 [0:63];

  int checks;
  int errors;
  int gnt_both;
  int rdy_both;

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(2), .MAX_DBURST(4)) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdy(if_rdy), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(1), .MAX_DBURST(4)) dut1 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rdy(if_rdy1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rdy(d_rdy1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: preloaded while in reset, written on enabled store cycles.
  assign mem_rdata  = mem[mem_addr[5:0]];
  assign mem_rdata1 = mem1[mem_addr1[5:0]];

  always @(posedge clk) begin
    if (!rst_f) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= 32'h1000_0000 + 32'(i);
        mem1[i] <= 32'h1000_0000 + 32'(i);
      end
      mem[4]  <= 32'h8800_1000;
      mem1[4] <= 32'h8800_1000;
      mem1[8] <= 32'hA5A5_0001;
    end else begin
      if (mem_en && mem_we)   mem[mem_addr[5:0]]   <= mem_wdata;
      if (mem_en1 && mem_we1) mem1[mem_addr1[5:0]] <= mem_wdata1;
    end
  end

  // Grants and ready pulses must never collide on either instance.
  always @(negedge clk) begin
    if ((if_gnt && d_gnt) || (if_gnt1 && d_gnt1)) gnt_both++;
    if ((if_rdy && d_rdy) || (if_rdy1 && d_rdy1)) rdy_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          rdy_seen;
    int          ng;
    logic [5:0]  seq;

    checks = 0; errors = 0; gnt_both = 0; rdy_both = 0;
    rst_f = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt_rdy", 32'({if_gnt, d_gnt, if_rdy, d_rdy, mem_we}), 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);
    rst_f = 1'b1;
    tick();

    // Single fetch, MEM_LAT = 2
    if_req = 1'b1; if_addr = 16'h0004;
    tick();
    check("f_c1_gnt", 32'(if_gnt), 32'd1);
    check("f_c1_en", 32'({mem_en, mem_we, busy}), 32'b101);
    check("f_c1_addr", 32'(mem_addr), 32'h0004);
    if_req = 1'b0;
    tick();
    check("f_c2_en_gnt_rdy", 32'({mem_en, if_gnt, if_rdy}), 32'b100);
    tick();
    check("f_c3_rdy_en", 32'({if_rdy, mem_en}), 32'b10);
    check("f_c3_rdata", if_rdata, 32'h8800_1000);
    tick();
    check("f_c4_idle", 32'({if_rdy, busy}), 32'b00);
    check("f_c4_hold", if_rdata, 32'h8800_1000);

    // Reset in the middle of a fetch access
    if_req = 1'b1; if_addr = 16'h0004;
    tick();
    if_req = 1'b0;
    check("ra_in_access", 32'(mem_en), 32'd1);
    #2 rst_f = 1'b0;
    #1;
    check("ra_outs", 32'({mem_en, mem_we, if_gnt, if_rdy, d_gnt, d_rdy, busy}), 32'd0);
    check("ra_if_rdata", if_rdata, 32'd0);
    tick();
    #1 rst_f = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if_rdy) rdy_seen++;
    end
    check("ra_no_rdy", 32'(rdy_seen), 32'd0);
    check("ra_idle", 32'(busy), 32'd0);

    // Store then load at 0x0010
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_c1", 32'({d_gnt, mem_en, mem_we}), 32'b111);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();
    check("st_c2_we", 32'({mem_en, mem_we}), 32'b11);
    tick();
    check("st_c3", 32'({d_rdy, mem_en, mem_we}), 32'b100);
    check("st_rdata_unch", d_rdata, 32'd0);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    tick();
    check("ld_c1", 32'({d_gnt, mem_en, mem_we}), 32'b110);
    d_req = 1'b0;
    tick();
    check("ld_c2_we", 32'(mem_we), 32'd0);
    tick();
    check("ld_c3_rdy", 32'(d_rdy), 32'd1);
    check("ld_rdata", d_rdata, 32'hDEAD_BEEF);

    // Back-to-back: new load raised during DONE
    d_req = 1'b1; d_addr = 16'h0004;
    tick();
    check("bb_c4", 32'({d_gnt, mem_en, busy}), 32'b111);
    check("bb_addr", 32'(mem_addr), 32'h0004);
    d_req = 1'b0;
    tick();
    tick();
    check("bb_c6_rdy", 32'(d_rdy), 32'd1);
    check("bb_rdata", d_rdata, 32'h8800_1000);
    tick(); tick();

    // Both requesting continuously: burst limit lets a fetch through after 4 data grants
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    ng = 0; seq = '0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      tick();
      if (if_gnt) begin
        seq[ng] = 1'b0; ng++;
      end else if (d_gnt) begin
        seq[ng] = 1'b1; ng++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("burst_count", 32'(ng), 32'd6);
    check("burst_order", 32'(seq), 32'b10_1111);
    for (int c = 0; c < 6; c++) tick();
    check("burst_drain", 32'({busy, busy1}), 32'b00);

    // MEM_LAT = 1 boundary on the second instance
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0008;
    tick();
    check("l1_c1", 32'({d_gnt1, mem_en1, busy1}), 32'b111);
    d_req = 1'b0;
    tick();
    check("l1_c2", 32'({d_rdy1, mem_en1, busy1}), 32'b101);
    check("l1_rdata", d_rdata1, 32'hA5A5_0001);
    tick();
    check("l1_c3", 32'({d_rdy1, busy1}), 32'b00);

    check("gnt_excl", 32'(gnt_both), 32'd0);
    check("rdy_excl", 32'(rdy_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
